// File: rtl/arb_pkg.sv
// Shared definitions for mem_port_arbiter: the FSM state encoding and default bus widths.
package arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_BUSY = 2'd1,
    IF_BUSY  = 2'd2,
    DONE     = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory backend between the IF and MEM pipeline stages.
// Define ARB_STARVE_GUARD_EN to force an IF grant after STARVE_LIMIT back-to-back MEM grants.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
`ifdef ARB_STARVE_GUARD_EN
  ,
  parameter int STARVE_LIMIT = 4
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_rd_en,
  input  logic              mem_wr_en,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              freeze_if,
  output logic              freeze_pipe,
  output logic              sram_req,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              sram_ack
);

  arb_state_e        state_q, state_d;
  logic              sram_req_q, sram_req_d;
  logic              sram_we_q, sram_we_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0] sram_wdata_q, sram_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              mem_ready_q, mem_ready_d;

  logic mem_req;
  logic force_if;
  logic grant_mem;
  logic grant_if;

  assign mem_req = mem_rd_en | mem_wr_en;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  assign force_if = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

  // Counts MEM grants that overtook a waiting fetch; any IF grant forgives the debt.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant_if)
      starve_cnt_d = '0;
    else if (grant_mem && if_req)
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      starve_cnt_q <= '0;
    else
      starve_cnt_q <= starve_cnt_d;
  end
`else
  assign force_if = 1'b0;
`endif

  // MEM normally wins a tie: its stall freezes the whole pipe and it belongs to the older instruction.
  assign grant_mem = (state_q == IDLE) && mem_req && !(force_if && if_req);
  assign grant_if  = (state_q == IDLE) && if_req && !grant_mem;

  always_comb begin
    state_d      = state_q;
    sram_req_d   = sram_req_q;
    sram_we_d    = sram_we_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;
    if_ready_d   = 1'b0;
    mem_ready_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_mem) begin
          state_d      = MEM_BUSY;
          sram_req_d   = 1'b1;
          sram_we_d    = mem_wr_en;
          sram_addr_d  = mem_addr;
          sram_wdata_d = mem_wdata;
        end else if (grant_if) begin
          state_d     = IF_BUSY;
          sram_req_d  = 1'b1;
          sram_we_d   = 1'b0;
          sram_addr_d = if_addr;
        end
      end
      MEM_BUSY: begin
        if (sram_ack) begin
          state_d     = DONE;
          sram_req_d  = 1'b0;
          mem_ready_d = 1'b1;
          if (!sram_we_q)
            mem_rdata_d = sram_rdata;
        end
      end
      IF_BUSY: begin
        if (sram_ack) begin
          state_d    = DONE;
          sram_req_d = 1'b0;
          if_ready_d = 1'b1;
          if_rdata_d = sram_rdata;
        end
      end
      // Requests are deliberately not sampled here so a stale request is never re-served.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sram_req_q   <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      if_ready_q   <= 1'b0;
      mem_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sram_req_q   <= sram_req_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
      if_ready_q   <= if_ready_d;
      mem_ready_q  <= mem_ready_d;
    end
  end

  assign sram_req    = sram_req_q;
  assign sram_we     = sram_we_q;
  assign sram_addr   = sram_addr_q;
  assign sram_wdata  = sram_wdata_q;
  assign if_rdata    = if_rdata_q;
  assign mem_rdata   = mem_rdata_q;
  assign if_ready    = if_ready_q;
  assign mem_ready   = mem_ready_q;
  assign freeze_if   = if_req & ~if_ready_q;
  assign freeze_pipe = mem_req & ~mem_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; inputs change and outputs are checked on the falling edge.
// Starvation expectations follow ARB_STARVE_GUARD_EN when it is defined for the build.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        freeze_if;
  logic        freeze_pipe;
  logic        sram_req;
  logic        sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_ack;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .if_ready    (if_ready),
    .mem_rd_en   (mem_rd_en),
    .mem_wr_en   (mem_wr_en),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .freeze_if   (freeze_if),
    .freeze_pipe (freeze_pipe),
    .sram_req    (sram_req),
    .sram_we     (sram_we),
    .sram_addr   (sram_addr),
    .sram_wdata  (sram_wdata),
    .sram_rdata  (sram_rdata),
    .sram_ack    (sram_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr, input logic memRd,
                               input logic memWr, input logic [31:0] memAddr, input logic [31:0] memWdata);
    if_req    = ifReq;
    if_addr   = ifAddr;
    mem_rd_en = memRd;
    mem_wr_en = memWr;
    mem_addr  = memAddr;
    mem_wdata = memWdata;
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  // Holds ack for one rising edge, leaving the bench in the cycle where ready should be high.
  task automatic pulseAck(input logic [31:0] rdata);
    sram_ack   = 1'b1;
    sram_rdata = rdata;
    nextCycle();
    sram_ack   = 1'b0;
    sram_rdata = 32'h0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_req"},    {31'b0, sram_req},  32'h0);
    checkOutput({tag, "_we"},     {31'b0, sram_we},   32'h0);
    checkOutput({tag, "_addr"},   sram_addr,          32'h0);
    checkOutput({tag, "_wdata"},  sram_wdata,         32'h0);
    checkOutput({tag, "_ifrd"},   if_rdata,           32'h0);
    checkOutput({tag, "_memrd"},  mem_rdata,          32'h0);
    checkOutput({tag, "_ifrdy"},  {31'b0, if_ready},  32'h0);
    checkOutput({tag, "_memrdy"}, {31'b0, mem_ready}, 32'h0);
  endtask

  initial begin
    rst        = 1'b1;
    sram_ack   = 1'b0;
    sram_rdata = 32'h0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();
    nextCycle();
    checkAllZero("reset");
    rst = 1'b0;
    nextCycle();

    // IF-only fetch with three wait cycles on the backend
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
    #1 checkOutput("if_freeze_at_req", {31'b0, freeze_if}, 32'h1);
    nextCycle();
    checkOutput("if_sram_req", {31'b0, sram_req}, 32'h1);
    checkOutput("if_sram_we", {31'b0, sram_we}, 32'h0);
    checkOutput("if_sram_addr", sram_addr, 32'h40);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkOutput("if_wait_req", {31'b0, sram_req}, 32'h1);
      checkOutput("if_wait_freeze", {31'b0, freeze_if}, 32'h1);
      checkOutput("if_wait_ready", {31'b0, if_ready}, 32'h0);
    end
    pulseAck(32'hE3A01005);
    checkOutput("if_ready", {31'b0, if_ready}, 32'h1);
    checkOutput("if_rdata", if_rdata, 32'hE3A01005);
    checkOutput("if_req_dropped", {31'b0, sram_req}, 32'h0);
    checkOutput("if_freeze_released", {31'b0, freeze_if}, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();
    checkOutput("if_ready_one_cycle", {31'b0, if_ready}, 32'h0);

    // Store: latched address/data must survive the requester changing its buses
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h400, 32'h12345678);
    #1 checkOutput("st_freeze_pipe", {31'b0, freeze_pipe}, 32'h1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h999, 32'hDEADBEEF);
    checkOutput("st_sram_we", {31'b0, sram_we}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("st_hold_req", {31'b0, sram_req}, 32'h1);
      checkOutput("st_hold_addr", sram_addr, 32'h400);
      checkOutput("st_hold_wdata", sram_wdata, 32'h12345678);
      nextCycle();
    end
    pulseAck(32'hBADBAD00);
    checkOutput("st_mem_ready", {31'b0, mem_ready}, 32'h1);
    checkOutput("st_mem_rdata_kept", mem_rdata, 32'h0);
    checkOutput("st_freeze_released", {31'b0, freeze_pipe}, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();
    checkOutput("st_ready_one_cycle", {31'b0, mem_ready}, 32'h0);

    // Simultaneous load and fetch: MEM first, IF only after DONE
    applyStimulus(1'b1, 32'h44, 1'b1, 1'b0, 32'h404, 32'h0);
    nextCycle();
    checkOutput("both_first_addr", sram_addr, 32'h404);
    checkOutput("both_first_we", {31'b0, sram_we}, 32'h0);
    pulseAck(32'h11112222);
    checkOutput("both_mem_ready", {31'b0, mem_ready}, 32'h1);
    checkOutput("both_mem_rdata", mem_rdata, 32'h11112222);
    checkOutput("both_if_not_ready", {31'b0, if_ready}, 32'h0);
    checkOutput("both_if_frozen", {31'b0, freeze_if}, 32'h1);
    applyStimulus(1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();
    checkOutput("both_done_no_req", {31'b0, sram_req}, 32'h0);
    nextCycle();
    checkOutput("both_if_grant_req", {31'b0, sram_req}, 32'h1);
    checkOutput("both_if_grant_addr", sram_addr, 32'h44);
    pulseAck(32'h33334444);
    checkOutput("both_if_ready", {31'b0, if_ready}, 32'h1);
    checkOutput("both_if_rdata", if_rdata, 32'h33334444);
    checkOutput("both_mem_rdata_hold", mem_rdata, 32'h11112222);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();

    // Request held through DONE must not be re-granted; stray ack in IDLE is ignored
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h408, 32'h0);
    nextCycle();
    checkOutput("hold_grant", {31'b0, sram_req}, 32'h1);
    pulseAck(32'h00000055);
    checkOutput("hold_ready", {31'b0, mem_ready}, 32'h1);
    nextCycle();
    checkOutput("hold_no_regrant", {31'b0, sram_req}, 32'h0);
    checkOutput("hold_single_pulse", {31'b0, mem_ready}, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();
    pulseAck(32'hFFFFFFFF);
    checkOutput("stray_mem_ready", {31'b0, mem_ready}, 32'h0);
    checkOutput("stray_if_ready", {31'b0, if_ready}, 32'h0);
    checkOutput("stray_req", {31'b0, sram_req}, 32'h0);
    checkOutput("stray_mem_rdata", mem_rdata, 32'h00000055);

    // Reset in the middle of a load, then a late ack
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 32'h0);
    nextCycle();
    checkOutput("rst_pre_req", {31'b0, sram_req}, 32'h1);
    rst = 1'b1;
    #1 checkAllZero("midrst");
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();
    rst = 1'b0;
    nextCycle();
    pulseAck(32'h0000AAAA);
    checkOutput("late_ack_req", {31'b0, sram_req}, 32'h0);
    checkOutput("late_ack_ready", {31'b0, mem_ready}, 32'h0);
    checkOutput("late_ack_rdata", mem_rdata, 32'h0);
    applyStimulus(1'b1, 32'h60, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();
    checkOutput("post_rst_req", {31'b0, sram_req}, 32'h1);
    checkOutput("post_rst_addr", sram_addr, 32'h60);
    pulseAck(32'h0000600D);
    checkOutput("post_rst_if_ready", {31'b0, if_ready}, 32'h1);
    checkOutput("post_rst_if_rdata", if_rdata, 32'h0000600D);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();

    // Continuous loads with a waiting fetch
    applyStimulus(1'b1, 32'h80, 1'b1, 1'b0, 32'h700, 32'h0);
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      checkOutput("starve_mem_addr", sram_addr, 32'h700);
      pulseAck(32'h70 + 32'(i));
      checkOutput("starve_mem_ready", {31'b0, mem_ready}, 32'h1);
      nextCycle();
    end
    nextCycle();
    checkOutput("starve_5th_req", {31'b0, sram_req}, 32'h1);
`ifdef ARB_STARVE_GUARD_EN
    checkOutput("starve_5th_addr", sram_addr, 32'h80);
    pulseAck(32'h00000077);
    checkOutput("starve_if_ready", {31'b0, if_ready}, 32'h1);
    checkOutput("starve_if_rdata", if_rdata, 32'h00000077);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();
`else
    checkOutput("starve_5th_addr", sram_addr, 32'h700);
    pulseAck(32'h00000077);
    checkOutput("starve_mem5_ready", {31'b0, mem_ready}, 32'h1);
    checkOutput("starve_if_waiting", {31'b0, if_ready}, 32'h0);
    applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();
    nextCycle();
    checkOutput("starve_if_addr", sram_addr, 32'h80);
    pulseAck(32'h00000088);
    checkOutput("starve_if_ready", {31'b0, if_ready}, 32'h1);
    checkOutput("starve_if_rdata", if_rdata, 32'h00000088);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
